// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and constants for uart_tx_arbiter.
package uart_arb_pkg;
    typedef enum logic [1:0] {IDLE, START, WAIT_DONE} arb_state_e;
    localparam int BYTE_W = 8;
    localparam int TIMEOUT_DEFAULT = 131072;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake plus UART transmitter control bundle.
// master is the arbiter side; slave is the requesters and UART side.
interface uart_tx_arbiter_if #(parameter int NUM_REQ = 4);
    import uart_arb_pkg::*;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_last;
    logic [NUM_REQ-1:0] req_ready;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic uart_tx_enable;
    logic uart_tx_start;
    logic uart_tx_busy;
    logic uart_tx_done;
    logic [BYTE_W-1:0] uart_tx_data;
    modport master (
        input  req_valid, req_data, req_last, uart_tx_busy, uart_tx_done,
        output req_ready, uart_tx_enable, uart_tx_start, uart_tx_data
    );
    modport slave (
        output req_valid, req_data, req_last, uart_tx_busy, uart_tx_done,
        input  req_ready, uart_tx_enable, uart_tx_start, uart_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection, searching upward from ptr with wrap.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic               found,
    output logic [IDW-1:0]     idx
);
    logic [IDW-1:0] j;
    always_comb begin
        found = |req;
        idx = '0;
        j = '0;
        // Walk downward so the candidate nearest to ptr is assigned last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IDW'((int'(ptr) + k) % NUM_REQ);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ byte producers with packet lock.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    uart_tx_arbiter_if.master  bus,
    output logic [IDW-1:0]     grant_id,
    output logic               arb_busy,
    output logic               byte_done,
    output logic               timeout
);
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported parameter values");
    end
    arb_state_e state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d, grant_q, grant_d, win, next_ptr;
    logic lock_q, lock_d, last_q, last_d, byte_done_q, byte_done_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic [NUM_REQ-1:0] elig;
    logic found, accept, wd_fire;
    // While locked, grant_q doubles as the lock owner.
    assign elig = lock_q ? (bus.req_valid & (NUM_REQ'(1) << grant_q)) : bus.req_valid;
    assign next_ptr = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    rr_picker #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr_picker (
        .req(elig), .ptr(rr_ptr_q), .found(found), .idx(win)
    );
`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    assign wd_cnt_d = (state_q == WAIT_DONE) ? wd_cnt_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) wd_cnt_q <= '0;
        else wd_cnt_q <= wd_cnt_d;
    end
    // A coincident uart_tx_done takes priority over the abort.
    assign wd_fire = state_q == WAIT_DONE && !bus.uart_tx_done && wd_cnt_q == CW'(TIMEOUT_CYCLES - 1);
`else
    assign wd_fire = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d = grant_q;
        lock_d = lock_q;
        last_d = last_q;
        data_d = data_q;
        byte_done_d = 1'b0;
        accept = resetn && state_q == IDLE && en && !bus.uart_tx_busy && found;
        bus.req_ready = accept ? NUM_REQ'(1) << win : '0;
        case (state_q)
            IDLE: if (accept) begin
                state_d = START;
                data_d = bus.req_data[win*BYTE_W +: BYTE_W];
                grant_d = win;
                last_d = bus.req_last[win];
            end
            START: state_d = WAIT_DONE;
            WAIT_DONE: if (bus.uart_tx_done) begin
                state_d = IDLE;
                byte_done_d = 1'b1;
                lock_d = !last_q;
                if (last_q) rr_ptr_d = next_ptr;
            end else if (wd_fire) begin
                state_d = IDLE;
                lock_d = 1'b0;
                rr_ptr_d = next_ptr;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            grant_q <= '0;
            lock_q <= 1'b0;
            last_q <= 1'b0;
            data_q <= '0;
            byte_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q <= grant_d;
            lock_q <= lock_d;
            last_q <= last_d;
            data_q <= data_d;
            byte_done_q <= byte_done_d;
        end
    end
    assign bus.uart_tx_start = state_q == START;
    assign bus.uart_tx_enable = en || state_q != IDLE;
    assign bus.uart_tx_data = data_q;
    assign grant_id = grant_q;
    assign arb_busy = state_q != IDLE || lock_q;
    assign byte_done = byte_done_q;
    assign timeout = wd_fire;
endmodule
